// File: rtl/uart_mmio_ctrl_if.sv
// Data-memory bus between the core's memory stage and the UART register window.
interface uart_mmio_ctrl_if;
  logic [3:0]  mem_en;
  logic        mem_wea;
  logic        mem_rea;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (output mem_en, mem_wea, mem_rea, mem_addr, mem_din, input mem_dout);
  modport slave  (input mem_en, mem_wea, mem_rea, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART: 16-byte register window, TX FIFO + serialiser, RX deserialiser + buffer, level IRQ.
// Define UART_RX_FIFO_EN for an RX FIFO of FIFO_DEPTH entries; otherwise RX uses a single holding register.
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             Rst,
  uart_mmio_ctrl_if.slave  bus,
  input  logic             rx,
  output logic             tx,
  output logic             uart_IRQ
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic       w_hit, w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd_rx;
  logic [1:0] w_sel;
  assign w_hit     = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = bus.mem_addr[3:2];
  assign w_wr_tx   = w_hit & bus.mem_wea & (w_sel == 2'd0) & bus.mem_en[0];
  assign w_rd_rx   = w_hit & bus.mem_rea & (w_sel == 2'd1);
  assign w_wr_stat = w_hit & bus.mem_wea & (w_sel == 2'd2);
  assign w_wr_ctrl = w_hit & bus.mem_wea & (w_sel == 2'd3) & bus.mem_en[0];

  logic w_unused;
  assign w_unused = ^{bus.mem_en[3:1], bus.mem_din[31:8], bus.mem_addr[1:0]};

  // ---------------- TX FIFO ----------------
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;
  logic [PW:0] r_tx_cnt;
  logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_drop;
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_tx_push  = w_wr_tx & (~w_tx_full | w_tx_pop);
  assign w_tx_drop  = w_wr_tx & w_tx_full & ~w_tx_pop;

  // NOTE: storage arrays carry no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.mem_din[7:0];
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (PW+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  state_t        r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_clk;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx, w_tx_line, w_tx_bit_end, w_tx_busy;
  assign w_tx_bit_end = (r_tx_clk == BIT_LAST);
  assign w_tx_busy    = (r_tx_state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    w_tx_line      = 1'b1;
    case (r_tx_state)
      S_IDLE:  if (!w_tx_empty) begin
                 w_tx_state_nxt = S_START;
                 w_tx_pop       = 1'b1;
               end
      S_START: begin
                 w_tx_line = 1'b0;
                 if (w_tx_bit_end) w_tx_state_nxt = S_DATA;
               end
      S_DATA:  begin
                 w_tx_line = r_tx_shift[0];
                 if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
               end
      S_STOP:  if (w_tx_bit_end) begin
                 if (!w_tx_empty) begin
                   w_tx_state_nxt = S_START;
                   w_tx_pop       = 1'b1;
                 end else begin
                   w_tx_state_nxt = S_IDLE;
                 end
               end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_clk   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_tx_line;
      if (w_tx_pop)                                r_tx_shift <= r_tx_mem[r_tx_rp];
      else if (r_tx_state == S_DATA && w_tx_bit_end) r_tx_shift <= r_tx_shift >> 1;
      if (r_tx_state == S_IDLE || w_tx_bit_end)    r_tx_clk <= '0;
      else                                         r_tx_clk <= r_tx_clk + CW'(1);
      if (r_tx_state != S_DATA)                    r_tx_bit <= '0;
      else if (w_tx_bit_end)                       r_tx_bit <= r_tx_bit + 3'd1;
    end
  end
  assign tx = r_tx;

  // ---------------- RX synchroniser and deserialiser ----------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  state_t        r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_clk;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_half, w_rx_bit_end, w_rx_stop_smp;
  assign w_rx_half    = (r_rx_clk == HALF_LAST);
  assign w_rx_bit_end = (r_rx_clk == BIT_LAST);

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_stop_smp  = 1'b0;
    case (r_rx_state)
      S_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = S_START;
      S_START: if (w_rx_half) w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
      S_STOP:  if (w_rx_bit_end) begin
                 w_rx_state_nxt = S_IDLE;
                 w_rx_stop_smp  = 1'b1;
               end
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_state_nxt;
  end

  // START counts to the bit midpoint; later states count whole bits from there.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rx_clk   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if (r_rx_state == S_IDLE || (r_rx_state == S_START && w_rx_half) ||
          (r_rx_state != S_START && w_rx_bit_end))
        r_rx_clk <= '0;
      else
        r_rx_clk <= r_rx_clk + CW'(1);
      if (r_rx_state != S_DATA) r_rx_bit <= '0;
      else if (w_rx_bit_end) begin
        r_rx_bit   <= r_rx_bit + 3'd1;
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
      end
    end
  end

  // ---------------- RX buffer ----------------
  logic       w_rx_empty, w_rx_full, w_rx_push_req, w_rx_push, w_rx_pop, w_rx_drop;
  logic [7:0] w_rx_head;
  assign w_rx_push_req = w_rx_stop_smp & r_rx_sync;
  assign w_rx_pop      = w_rd_rx & ~w_rx_empty;
  assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);
  assign w_rx_drop     = w_rx_push_req & w_rx_full & ~w_rx_pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [PW:0]   r_rx_cnt;
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (PW+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end
`else
  logic [7:0] r_rx_hold;
  logic       r_rx_valid;
  assign w_rx_empty = ~r_rx_valid;
  assign w_rx_full  = r_rx_valid;
  assign w_rx_head  = r_rx_hold;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rx_hold  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_rx_push)     r_rx_hold  <= r_rx_shift;
      if (w_rx_push)     r_rx_valid <= 1'b1;
      else if (w_rx_pop) r_rx_valid <= 1'b0;
    end
  end
`endif

  // ---------------- Registers, read mux, IRQ ----------------
  logic        r_tx_ovf, r_rx_ovr, r_frame_err, r_irq;
  logic [1:0]  r_ctrl;
  logic [31:0] r_dout, w_rdata, w_status;
  assign w_status = {24'h0, r_frame_err, r_rx_ovr, r_tx_ovf, w_tx_busy,
                     w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      2'd1:    w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
      2'd2:    w_rdata = w_status;
      2'd3:    w_rdata = {30'h0, r_ctrl};
      default: w_rdata = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as its write-1-to-clear wins.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_ovf    <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_ctrl      <= '0;
      r_irq       <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_tx_ovf    <= w_tx_drop | (r_tx_ovf & ~(w_wr_stat & bus.mem_din[5]));
      r_rx_ovr    <= w_rx_drop | (r_rx_ovr & ~(w_wr_stat & bus.mem_din[6]));
      r_frame_err <= (w_rx_stop_smp & ~r_rx_sync) |
                     (r_frame_err & ~(w_wr_stat & bus.mem_din[7]));
      if (w_wr_ctrl) r_ctrl <= bus.mem_din[1:0];
      r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty & ~w_tx_busy);
      if (bus.mem_rea || bus.mem_wea)
        r_dout <= (w_hit && bus.mem_rea) ? w_rdata : 32'h0;
    end
  end

  assign bus.mem_dout = r_dout;
  assign uart_IRQ     = r_irq;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: queued expectations checked by independent load and TX-line monitors.
module tb_uart_mmio_ctrl;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_RX_FIFO_EN
  localparam int RX_CAP = DEPTH;
`else
  localparam int RX_CAP = 1;
`endif

  logic clk = 1'b0;
  logic Rst;
  logic rx;
  logic tx;
  logic uart_IRQ;

  uart_mmio_ctrl_if bus();

  uart_mmio_ctrl #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .Rst(Rst), .bus(bus), .rx(rx), .tx(tx), .uart_IRQ(uart_IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } load_t;

  int          checks = 0;
  int          failures = 0;
  load_t       load_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_tx_ovf = 1'b0, m_rx_ovr = 1'b0, m_frame_err = 1'b0;
  int          tx_frames = 0;
  int          tx_epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {24'h0, m_frame_err, m_rx_ovr, m_tx_ovf, 1'b0,
            rx_q.size() == RX_CAP, rx_q.size() == 0, 1'b0, 1'b1};
  endfunction

  task automatic bus_idle();
    bus.mem_en = 4'h0; bus.mem_wea = 1'b0; bus.mem_rea = 1'b0;
    bus.mem_addr = 32'h0; bus.mem_din = 32'h0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] en = 4'hF);
    bus.mem_addr = BASE | {28'h0, off}; bus.mem_din = d; bus.mem_en = en; bus.mem_wea = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp,
                          input logic [31:0] mask, input string name);
    load_t e;
    e.exp = exp; e.mask = mask; e.name = name;
    load_q.push_back(e);
    bus.mem_addr = addr; bus.mem_en = 4'hF; bus.mem_rea = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_status(input string name);
    bus_read(BASE | 32'h8, exp_status(), 32'hFFFF_FFFF, name);
  endtask

  task automatic read_rx(input string name);
    logic [31:0] e;
    e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    bus_read(BASE | 32'h4, e, 32'hFFFF_FFFF, name);
  endtask

  task automatic clear_stickies();
    bus_write(4'h8, 32'h0000_00E0);
    m_tx_ovf = 1'b0; m_rx_ovr = 1'b0; m_frame_err = 1'b0;
  endtask

  // Burst of stores from an idle transmitter: the shifter takes the first byte, DEPTH more queue up.
  task automatic tx_burst(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      bus_write(4'h0, {24'h0, b});
      if (i < DEPTH + 1) tx_q.push_back(b);
      else               m_tx_ovf = 1'b1;
    end
  endtask

  task automatic wait_tx_drain(input string name);
    int cyc = 0;
    while (tx_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check(name, tx_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (CPB) @(negedge clk);
    end
    rx = stop_bit; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (2) @(negedge clk);
    if (stop_bit) begin
      if (rx_q.size() < RX_CAP) rx_q.push_back(b);
      else                      m_rx_ovr = 1'b1;
    end else begin
      m_frame_err = 1'b1;
    end
  endtask

  // Load monitor: every sampled load yields mem_dout on the next cycle.
  initial begin : load_monitor
    forever begin
      @(posedge clk);
      if (bus.mem_rea === 1'b1 && Rst === 1'b0) begin
        #1;
        if (load_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL load_unexpected: got %h expected no load", bus.mem_dout);
        end else begin
          load_t e;
          e = load_q.pop_front();
          check(e.name, bus.mem_dout & e.mask, e.exp & e.mask);
        end
      end
    end
  end

  // TX monitor: decodes each frame at bit midpoints; frames cut by reset are discarded via the epoch.
  initial begin : tx_monitor
    forever begin
      logic [9:0] bits;
      int ep;
      @(negedge tx);
      ep = tx_epoch;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bits[i] = tx;
        if (i < 9) repeat (CPB) @(negedge clk);
      end
      if (ep == tx_epoch) begin
        tx_frames++;
        check("tx_framing", {30'h0, bits[9], bits[0]}, 32'h2);
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got %h expected no frame", bits[8:1]);
        end else begin
          check("tx_byte", {24'h0, bits[8:1]}, {24'h0, tx_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int f0;
    bus_idle();
    rx = 1'b1; Rst = 1'b1;
    repeat (3) @(negedge clk);
    Rst = 1'b0;

    check("reset_tx", tx, 1);
    check("reset_irq", uart_IRQ, 0);
    check("reset_dout", bus.mem_dout, 0);
    bus_read(BASE | 32'h8, 32'h0000_0005, 32'hFFFF_FFFF, "reset_status");
    bus_read(32'h0000_2008, 32'h0, 32'hFFFF_FFFF, "nonhit_read");
    bus_read(BASE | 32'hC, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");

    // TX latency and frame length: two stores on consecutive edges.
    bus_write(4'h0, 32'hA5); tx_q.push_back(8'hA5);
    check("tx_lat_e0", tx, 1);
    bus_write(4'h0, 32'h5A); tx_q.push_back(8'h5A);
    check("tx_lat_e1", tx, 1);
    @(negedge clk);
    check("tx_lat_e2", tx, 0);
    repeat (39) @(negedge clk);
    check("tx_frame_stop", tx, 1);
    @(negedge clk);
    check("tx_frame_next_start", tx, 0);
    bus_read(BASE | 32'h8, 32'h10, 32'h10, "status_tx_busy");
    wait_tx_drain("tx_drain_a5");
    read_status("status_idle");

    // TX overflow: 10 back-to-back stores, 9 accepted.
    f0 = tx_frames;
    tx_burst(10);
    bus_read(BASE | 32'h8, 32'h32, 32'h32, "status_tx_ovf_full");
    wait_tx_drain("tx_drain_ovf");
    check("tx_ovf_frames", tx_frames - f0, 9);
    bus_write(4'h8, 32'h20); m_tx_ovf = 1'b0;
    read_status("status_ovf_cleared");

    // Random TX bursts, some of which overflow.
    for (int r = 0; r < 3; r++) begin
      tx_burst($urandom_range(1, DEPTH + 3));
      wait_tx_drain("tx_drain_rand");
      read_status("status_rand_tx");
      clear_stickies();
    end

    // RX with interrupt.
    bus_write(4'hC, 32'h1);
    bus_read(BASE | 32'hC, 32'h1, 32'hFFFF_FFFF, "ctrl_readback");
    check("irq_idle", uart_IRQ, 0);
    send_rx_frame(8'h3C, 1'b1);
    check("irq_rx", uart_IRQ, 1);
    read_rx("rx_3c");
    check("irq_hold", uart_IRQ, 1);
    @(negedge clk);
    check("irq_drop", uart_IRQ, 0);

    // TX-idle interrupt and byte-enable gating on CTRL.
    bus_write(4'hC, 32'h2);
    @(negedge clk);
    check("irq_tx_idle", uart_IRQ, 1);
    bus_write(4'hC, 32'h3, 4'hE);
    bus_read(BASE | 32'hC, 32'h2, 32'hFFFF_FFFF, "ctrl_en_gated");
    bus_write(4'hC, 32'h0);
    repeat (2) @(negedge clk);
    check("irq_off", uart_IRQ, 0);

    // Random RX bytes.
    for (int k = 0; k < 4; k++) begin
      send_rx_frame(8'($urandom), 1'b1);
      read_rx("rx_rand");
    end

    // Framing error and glitch.
    send_rx_frame(8'($urandom), 1'b0);
    read_status("status_frame_err");
    read_rx("rx_after_frame_err");
    clear_stickies();
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    repeat (3 * CPB + 4) @(negedge clk);
    read_status("status_glitch");
    read_rx("rx_after_glitch");

    // Overrun: 9 frames, no reads.
    for (int k = 0; k < 9; k++) send_rx_frame(8'($urandom), 1'b1);
    read_status("status_rx_ovr");
    for (int k = 0; k < 9; k++) read_rx("rx_drain");
    read_status("status_rx_drained");
    clear_stickies();
    read_status("status_rx_clear");

    // Reset in the middle of a TX frame with more bytes queued.
    bus_write(4'h0, {24'h0, 8'($urandom)});
    bus_write(4'h0, {24'h0, 8'($urandom)});
    bus_write(4'h0, {24'h0, 8'($urandom)});
    repeat (12) @(negedge clk);
    tx_epoch++;
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    check("rst_mid_tx", tx, 1);
    rx_q.delete();
    m_tx_ovf = 1'b0; m_rx_ovr = 1'b0; m_frame_err = 1'b0;
    bus_read(BASE | 32'h8, 32'h0000_0005, 32'hFFFF_FFFF, "rst_mid_status");
    repeat (45) @(negedge clk);
    f0 = tx_frames;
    tx_burst(1);
    wait_tx_drain("tx_drain_after_rst");
    check("tx_after_rst_frames", tx_frames - f0, 1);

    repeat (4) @(negedge clk);
    check("load_q_drained", load_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
